// File: rtl/reg_file_nzp.sv
// reg_file_nzp
//   LC-3 datapath register file: NUM_REGS x WIDTH storage with two
//   combinational read ports and one synchronous write port, plus the NZP
//   condition-code register and the BEN branch-enable flag. A sequenced
//   clear engine zeroes the file one register per cycle on request.
//
// Parameters
//   WIDTH     data width of each register, of D and of the read outputs
//   NUM_REGS  number of registers (>= 2); AW = $clog2(NUM_REGS)
//
// Ports
//   Clk        in   1      clock, all state updates on posedge
//   Reset      in   1      asynchronous active-low reset
//   LD_REG     in   1      write strobe: R[DR] <= D (ignored while Busy)
//   DR         in   AW     write address
//   SR1, SR2   in   AW     read addresses
//   D          in   WIDTH  write data and condition-code source
//   LD_CC      in   1      load NZP from D (ignored while Busy)
//   LD_BEN     in   1      load BEN <= |(IR_nzp & NZP), uses pre-edge NZP
//   IR_nzp     in   3      branch-condition mask IR[11:9]
//   Clear_Req  in   1      start clear sequence (sampled only in IDLE)
//   SR1_Out    out  WIDTH  R[SR1], 0 for out-of-range address
//   SR2_Out    out  WIDTH  R[SR2], 0 for out-of-range address
//   NZP_Out    out  3      {N,Z,P}
//   BEN_Out    out  1      branch enable
//   Busy       out  1      high while the clear sequence runs
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read of the register being written in
//                      the same cycle returns D (write-through); otherwise
//                      reads always return stored contents.

module reg_file_nzp #(
  parameter  int WIDTH    = 16,
  parameter  int NUM_REGS = 8,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  input  logic [WIDTH-1:0] D,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic [2:0]       IR_nzp,
  input  logic             Clear_Req,
  output logic [WIDTH-1:0] SR1_Out,
  output logic [WIDTH-1:0] SR2_Out,
  output logic [2:0]       NZP_Out,
  output logic             BEN_Out,
  output logic             Busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [2:0]       nzp_q, nzp_d;
  logic             ben_q, ben_d;

  logic             busy;
  logic             wr_en;
  logic             cnt_last;
  logic             cc_n, cc_z, cc_p;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NUM_REGS));
  endfunction

  assign busy     = (state_q == CLEAR);
  assign wr_en    = LD_REG && !busy && in_range(DR);
  assign cnt_last = (cnt_q == AW'(NUM_REGS - 1));

  assign cc_n = D[WIDTH-1];
  assign cc_z = (D == '0);
  assign cc_p = !cc_n && !cc_z;

  // Clear engine: entering CLEAR resets the counter, each CLEAR edge zeroes
  // R[cnt]; the edge that zeroes the last register returns to IDLE, so Busy
  // is high for exactly NUM_REGS cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Clear_Req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Writes and clears never coincide: writes need !busy, clears need busy.
  // A write in the same IDLE cycle as Clear_Req lands and is later cleared.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[DR] = D;
    end
    if (busy) begin
      regs_d[cnt_q] = '0;
    end
  end

  always_comb begin
    nzp_d = nzp_q;
    ben_d = ben_q;
    if (LD_CC && !busy) begin
      nzp_d = {cc_n, cc_z, cc_p};
    end
    // BEN samples the registered NZP, so a simultaneous LD_CC is not seen.
    if (LD_BEN) begin
      ben_d = |(IR_nzp & nzp_q);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nzp_q   <= '0;
      ben_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nzp_q   <= nzp_d;
      ben_q   <= ben_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    SR1_Out = in_range(SR1) ? regs_q[SR1] : '0;
    SR2_Out = in_range(SR2) ? regs_q[SR2] : '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (DR == SR1)) begin
      SR1_Out = D;
    end
    if (wr_en && (DR == SR2)) begin
      SR2_Out = D;
    end
`endif
  end

  assign NZP_Out = nzp_q;
  assign BEN_Out = ben_q;
  assign Busy    = busy;

endmodule

// File: tb/tb_reg_file_nzp.sv
// Directed, table-driven bench for reg_file_nzp (WIDTH=16, NUM_REGS=8).
module tb_reg_file_nzp;

  logic        Clk;
  logic        Reset;
  logic        LD_REG;
  logic [2:0]  DR, SR1, SR2;
  logic [15:0] D;
  logic        LD_CC, LD_BEN;
  logic [2:0]  IR_nzp;
  logic        Clear_Req;
  logic [15:0] SR1_Out, SR2_Out;
  logic [2:0]  NZP_Out;
  logic        BEN_Out;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  reg_file_nzp #(.WIDTH(16), .NUM_REGS(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .LD_REG    (LD_REG),
    .DR        (DR),
    .SR1       (SR1),
    .SR2       (SR2),
    .D         (D),
    .LD_CC     (LD_CC),
    .LD_BEN    (LD_BEN),
    .IR_nzp    (IR_nzp),
    .Clear_Req (Clear_Req),
    .SR1_Out   (SR1_Out),
    .SR2_Out   (SR2_Out),
    .NZP_Out   (NZP_Out),
    .BEN_Out   (BEN_Out),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        ld_reg;
    logic [2:0]  dr;
    logic [15:0] d;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        ld_cc;
    logic        ld_ben;
    logic [2:0]  ir;
    logic [15:0] e_sr1;
    logic [15:0] e_sr2;
    logic [2:0]  e_nzp;
    logic        e_ben;
  } vec_t;

  vec_t vq[$];
  logic [15:0] model [8];
  logic [15:0] exp_byp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drop_strobes();
    LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0; Clear_Req = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    drop_strobes();
    DR = '0; SR1 = 3'd3; SR2 = 3'd5; D = '0; IR_nzp = '0;

    // Reset state
    #12;
    check("rst_sr1", SR1_Out, 16'h0);
    check("rst_sr2", SR2_Out, 16'h0);
    check("rst_nzp", NZP_Out, 3'b000);
    check("rst_ben", BEN_Out, 1'b0);
    check("rst_busy", Busy, 1'b0);
    Reset = 1'b1;

    //                  ld dr   d        s1   s2   cc   ben  ir      e_sr1     e_sr2     nzp     ben
    vq.push_back(vec_t'{1, 3'd3, 16'h8001, 3'd3, 3'd5, 1, 0, 3'b000, 16'h8001, 16'h0000, 3'b100, 0});
    vq.push_back(vec_t'{1, 3'd5, 16'h0000, 3'd3, 3'd5, 0, 0, 3'b000, 16'h8001, 16'h0000, 3'b100, 0});
    vq.push_back(vec_t'{0, 3'd0, 16'h0000, 3'd3, 3'd5, 1, 0, 3'b000, 16'h8001, 16'h0000, 3'b010, 0});
    vq.push_back(vec_t'{0, 3'd0, 16'h0005, 3'd3, 3'd5, 1, 1, 3'b001, 16'h8001, 16'h0000, 3'b001, 0});
    vq.push_back(vec_t'{0, 3'd0, 16'h0000, 3'd3, 3'd5, 0, 1, 3'b001, 16'h8001, 16'h0000, 3'b001, 1});
    vq.push_back(vec_t'{1, 3'd0, 16'hFFFF, 3'd0, 3'd3, 1, 1, 3'b100, 16'hFFFF, 16'h8001, 3'b100, 0});
    vq.push_back(vec_t'{1, 3'd7, 16'h7FFF, 3'd7, 3'd0, 1, 1, 3'b011, 16'h7FFF, 16'hFFFF, 3'b001, 0});
    vq.push_back(vec_t'{0, 3'd0, 16'h0000, 3'd7, 3'd5, 0, 1, 3'b111, 16'h7FFF, 16'h0000, 3'b001, 1});
    vq.push_back(vec_t'{1, 3'd1, 16'h1111, 3'd1, 3'd3, 0, 0, 3'b000, 16'h1111, 16'h8001, 3'b001, 1});
    vq.push_back(vec_t'{1, 3'd2, 16'h2222, 3'd2, 3'd3, 0, 0, 3'b000, 16'h2222, 16'h8001, 3'b001, 1});
    vq.push_back(vec_t'{1, 3'd4, 16'h4444, 3'd4, 3'd3, 0, 0, 3'b000, 16'h4444, 16'h8001, 3'b001, 1});
    vq.push_back(vec_t'{1, 3'd5, 16'h5555, 3'd5, 3'd3, 0, 0, 3'b000, 16'h5555, 16'h8001, 3'b001, 1});
    vq.push_back(vec_t'{1, 3'd6, 16'h6666, 3'd6, 3'd3, 0, 0, 3'b000, 16'h6666, 16'h8001, 3'b001, 1});

    foreach (vq[i]) begin
      LD_REG = vq[i].ld_reg; DR = vq[i].dr; D = vq[i].d;
      SR1 = vq[i].sr1; SR2 = vq[i].sr2;
      LD_CC = vq[i].ld_cc; LD_BEN = vq[i].ld_ben; IR_nzp = vq[i].ir;
      @(posedge Clk); #1;
      drop_strobes();
      #1;
      check($sformatf("v%0d_sr1", i), SR1_Out, vq[i].e_sr1);
      check($sformatf("v%0d_sr2", i), SR2_Out, vq[i].e_sr2);
      check($sformatf("v%0d_nzp", i), NZP_Out, vq[i].e_nzp);
      check($sformatf("v%0d_ben", i), BEN_Out, vq[i].e_ben);
      check($sformatf("v%0d_busy", i), Busy, 1'b0);
    end

    // Clear sequence; the write issued alongside Clear_Req lands first.
    model[0] = 16'hABCD; model[1] = 16'h1111; model[2] = 16'h2222; model[3] = 16'h8001;
    model[4] = 16'h4444; model[5] = 16'h5555; model[6] = 16'h6666; model[7] = 16'h7FFF;
    Clear_Req = 1'b1; LD_REG = 1'b1; DR = 3'd0; D = 16'hABCD; SR1 = 3'd0; SR2 = 3'd1;
    @(posedge Clk); #1;
    drop_strobes();
    #1;
    check("clr_start_busy", Busy, 1'b1);
    check("clr_start_r0", SR1_Out, 16'hABCD);
    check("clr_start_r1", SR2_Out, 16'h1111);
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) begin
        // Dropped while busy: write to R2, CC load, and a new clear request.
        LD_REG = 1'b1; DR = 3'd2; D = 16'hBEEF; LD_CC = 1'b1; Clear_Req = 1'b1;
      end
      @(posedge Clk); #1;
      drop_strobes();
      SR1 = 3'(i - 1);
      SR2 = (i < 8) ? 3'(i) : 3'd0;
      #1;
      check($sformatf("clr%0d_cleared", i), SR1_Out, 16'h0);
      if (i < 8) check($sformatf("clr%0d_next", i), SR2_Out, model[i]);
      check($sformatf("clr%0d_busy", i), Busy, (i < 8) ? 1'b1 : 1'b0);
    end
    SR1 = 3'd2;
    #1;
    check("clr_drop_r2", SR1_Out, 16'h0);
    check("clr_keep_nzp", NZP_Out, 3'b001);
    check("clr_keep_ben", BEN_Out, 1'b1);
    @(posedge Clk); #1;
    check("clr_no_requeue", Busy, 1'b0);

    // Reset during clear
    LD_REG = 1'b1; DR = 3'd6; D = 16'h6006;
    @(posedge Clk); #1;
    DR = 3'd1; D = 16'h1001;
    @(posedge Clk); #1;
    drop_strobes();
    Clear_Req = 1'b1;
    @(posedge Clk); #1;
    Clear_Req = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    SR1 = 3'd6; SR2 = 3'd1;
    #1;
    check("mid_busy", Busy, 1'b1);
    check("mid_r6", SR1_Out, 16'h6006);
    check("mid_r1", SR2_Out, 16'h0);
    Reset = 1'b0;
    #1;
    check("arst_busy", Busy, 1'b0);
    check("arst_r6", SR1_Out, 16'h0);
    check("arst_nzp", NZP_Out, 3'b000);
    check("arst_ben", BEN_Out, 1'b0);
    #1;
    Reset = 1'b1;
    Clear_Req = 1'b1;
    @(posedge Clk); #1;
    Clear_Req = 1'b0;
    check("reclr_busy0", Busy, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      check($sformatf("reclr_busy%0d", k), Busy, (k < 8) ? 1'b1 : 1'b0);
    end

    // Same-cycle read of the register being written
    LD_REG = 1'b1; DR = 3'd4; D = 16'h0001;
    @(posedge Clk); #1;
    D = 16'h1234; SR1 = 3'd4; SR2 = 3'd4;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 16'h1234;
`else
    exp_byp = 16'h0001;
`endif
    #1;
    check("byp_sr1_same", SR1_Out, exp_byp);
    check("byp_sr2_same", SR2_Out, exp_byp);
    @(posedge Clk); #1;
    LD_REG = 1'b0;
    #1;
    check("byp_sr1_next", SR1_Out, 16'h1234);
    check("byp_sr2_next", SR2_Out, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
